// File: rtl/maze_pkg.sv
// Shared maze geometry, cell-entry layout and constants for the maze lookup path.
package maze_pkg;

    localparam int unsigned MAZE_W     = 40;
    localparam int unsigned MAZE_H     = 30;
    localparam int unsigned MAZE_CELLS = MAZE_W * MAZE_H;
    localparam int unsigned IDX_W      = 11;

    // Bit 0 is the wall flag; bits 4:1 are the adjacent-wall flags.
    typedef struct packed {
        logic [3:0] adj;
        logic       wall;
    } maze_entry_t;

    localparam maze_entry_t ALL_WALLS = 5'b11111;

endpackage

// File: rtl/maze_lookup_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [PTR_W-1:0]   o_winner,
    output logic               o_valid,
    output logic [PTR_W-1:0]   o_next_ptr
);

    logic [PTR_W:0] w_cand;

    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        w_cand   = '0;
        // Scan from farthest to nearest so the nearest eligible candidate is kept.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = {1'b0, i_ptr} + (PTR_W + 1)'(k);
            if (w_cand >= (PTR_W + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (i_eligible[w_cand[PTR_W-1:0]]) begin
                o_valid  = 1'b1;
                o_winner = w_cand[PTR_W-1:0];
            end
        end
        o_next_ptr = i_ptr;
        if (o_valid) begin
            o_next_ptr = (o_winner == PTR_W'(NUM_REQ - 1)) ? '0 : o_winner + PTR_W'(1);
        end
    end

endmodule

// File: rtl/maze_lookup_arbiter.sv
// Round-robin sharing of the maze memory read port between pacman and the ghosts,
// with routing of the registered read data back to the granted requester.
module maze_lookup_arbiter #(
    parameter int unsigned NUM_REQ    = 5,
    parameter int unsigned MAZE_CELLS = maze_pkg::MAZE_CELLS
) (
    input  logic                                i_clk,
    input  logic                                i_reset,
    input  logic [NUM_REQ-1:0]                  i_req,
    input  logic [NUM_REQ*maze_pkg::IDX_W-1:0]  i_req_index,
    output logic [NUM_REQ-1:0]                  o_grant,
    output logic [NUM_REQ-1:0]                  o_rsp_valid,
    output logic [4:0]                          o_rsp_data,
    output logic [maze_pkg::IDX_W-1:0]          o_mem_index,
    input  logic [4:0]                          i_mem_data
);

    import maze_pkg::*;

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [IDX_W-1:0]   r_mem_index;
    logic               r_oor;
    logic               r_rsp_oor;
    logic [PTR_W-1:0]   r_ptr;

    logic [NUM_REQ-1:0] w_eligible;
    logic [PTR_W-1:0]   w_winner;
    logic               w_valid;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [IDX_W-1:0]   w_sel_index;
    logic               w_sel_oor;
    maze_entry_t        w_rsp_entry;

    // A requester granted this cycle still holds req high, so mask it out.
    assign w_eligible = i_req & ~r_grant;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_eligible (w_eligible),
        .i_ptr      (r_ptr),
        .o_winner   (w_winner),
        .o_valid    (w_valid),
        .o_next_ptr (w_next_ptr)
    );

    always_comb begin
        w_sel_index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == PTR_W'(i)) begin
                w_sel_index = i_req_index[i*IDX_W +: IDX_W];
            end
        end
        w_sel_oor = (w_sel_index >= IDX_W'(MAZE_CELLS));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_grant     <= '0;
            r_rsp_valid <= '0;
            r_mem_index <= '0;
            r_oor       <= 1'b0;
            r_rsp_oor   <= 1'b0;
            r_ptr       <= '0;
        end else begin
            r_rsp_valid <= r_grant;
            r_rsp_oor   <= r_oor;
            if (w_valid) begin
                r_grant     <= NUM_REQ'(1) << w_winner;
                r_mem_index <= w_sel_oor ? '0 : w_sel_index;
                r_oor       <= w_sel_oor;
                r_ptr       <= w_next_ptr;
            end else begin
                r_grant <= '0;
            end
        end
    end

    // Outputs are forced quiet while reset is held so an in-flight response never escapes.
    always_comb begin
        w_rsp_entry = '0;
        if (!i_reset && (r_rsp_valid != '0)) begin
            w_rsp_entry = r_rsp_oor ? ALL_WALLS : maze_entry_t'(i_mem_data);
        end
    end

    assign o_grant     = i_reset ? '0 : r_grant;
    assign o_rsp_valid = i_reset ? '0 : r_rsp_valid;
    assign o_mem_index = i_reset ? '0 : r_mem_index;
    assign o_rsp_data  = w_rsp_entry;

endmodule

// File: tb/tb_maze_lookup_arbiter.sv
// Self-checking bench for maze_lookup_arbiter against a cycle-level behavioural model.
module tb_maze_lookup_arbiter;

    localparam int N     = 5;
    localparam int CELLS = 1200;

    logic          clk;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*11-1:0] req_index;
    logic [N-1:0]  grant;
    logic [N-1:0]  rsp_valid;
    logic [4:0]    rsp_data;
    logic [10:0]   mem_index;
    logic [4:0]    mem_data;

    logic [4:0] mem [0:CELLS-1];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    logic [N-1:0] m_grant;
    int           m_gidx;
    bit           m_oor;
    int           m_mem_index;
    int           m_ptr;
    logic [N-1:0] m_rsp_valid;
    logic [4:0]   m_rsp_data;
    // Expected visible outputs
    logic [N-1:0] e_grant, e_rsp_valid;
    logic [4:0]   e_rsp_data;
    logic [10:0]  e_mem_index;

    maze_lookup_arbiter #(.NUM_REQ(N), .MAZE_CELLS(CELLS)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_req       (req),
        .i_req_index (req_index),
        .o_grant     (grant),
        .o_rsp_valid (rsp_valid),
        .o_rsp_data  (rsp_data),
        .o_mem_index (mem_index),
        .i_mem_data  (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= (int'(mem_index) < CELLS) ? mem[mem_index] : 5'h00;

    function automatic int get_idx(int i);
        return int'(req_index[i*11 +: 11]);
    endfunction

    task automatic set_idx(int i, int v);
        req_index[i*11 +: 11] = 11'(v);
    endtask

    task automatic model_step();
        int  win;
        int  c;
        logic [N-1:0] elig;
        if (reset) begin
            m_grant = '0; m_gidx = 0; m_oor = 0; m_mem_index = 0; m_ptr = 0;
            m_rsp_valid = '0; m_rsp_data = '0;
        end else begin
            m_rsp_valid = m_grant;
            m_rsp_data  = (m_grant != 0) ? (m_oor ? 5'h1f : mem[m_gidx]) : 5'h00;
            elig = req & ~m_grant;
            win  = -1;
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (win < 0 && elig[c]) win = c;
            end
            if (win >= 0) begin
                m_grant     = N'(1) << win;
                m_gidx      = get_idx(win);
                m_oor       = (m_gidx >= CELLS);
                m_mem_index = m_oor ? 0 : m_gidx;
                m_ptr       = (win + 1) % N;
            end else begin
                m_grant = '0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        e_grant     = reset ? '0 : m_grant;
        e_rsp_valid = reset ? '0 : m_rsp_valid;
        e_rsp_data  = reset ? '0 : m_rsp_data;
        e_mem_index = reset ? '0 : 11'(m_mem_index);
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 5'b11111;
        for (int i = 0; i < N; i++) set_idx(i, $urandom_range(0, CELLS - 1));
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++;
            if ({grant, rsp_valid, rsp_data, mem_index} !== '0) begin
                n_err++;
                $display("FAIL reset_outputs: got g=%b v=%b d=%h a=%0d want all zero",
                         grant, rsp_valid, rsp_data, mem_index);
            end
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (rsp_valid !== 5'b00000) begin
            n_err++; $display("FAIL reset_no_rsp: got %b want 00000", rsp_valid);
        end
        n_cmp++;
        if (grant !== 5'b00001) begin
            n_err++; $display("FAIL reset_first_grant: got %b want 00001", grant);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_single();
        req = 5'b00001; set_idx(0, 41);
        tick();
        n_cmp++;
        if (grant !== 5'b00001 || mem_index !== 11'd41) begin
            n_err++; $display("FAIL single_grant: got g=%b a=%0d want g=00001 a=41", grant, mem_index);
        end
        req = '0;
        tick();
        n_cmp++;
        if (rsp_valid !== 5'b00001 || rsp_data !== mem[41]) begin
            n_err++;
            $display("FAIL single_rsp: got v=%b d=%h want v=00001 d=%h", rsp_valid, rsp_data, mem[41]);
        end
        tick();
    endtask

    task automatic test_all_five();
        logic [N-1:0] prev;
        do_reset();
        req = 5'b11111;
        for (int i = 0; i < N; i++) set_idx(i, $urandom_range(0, CELLS - 1));
        prev = '0;
        for (int c = 0; c < 15; c++) begin
            tick();
            n_cmp++;
            if (grant !== (N'(1) << (c % N))) begin
                n_err++; $display("FAIL all5_order: cyc %0d got %b want %b", c, grant, N'(1) << (c % N));
            end
            n_cmp++;
            if ((grant & prev) != 0) begin
                n_err++; $display("FAIL all5_repeat: cyc %0d got %b after %b want disjoint", c, grant, prev);
            end
            n_cmp++;
            if (rsp_valid !== e_rsp_valid || rsp_data !== e_rsp_data) begin
                n_err++;
                $display("FAIL all5_rsp: cyc %0d got v=%b d=%h want v=%b d=%h",
                         c, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data);
            end
            prev = grant;
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_oor();
        int vals [2] = '{1200, 2047};
        for (int j = 0; j < 2; j++) begin
            req = 5'b00100; set_idx(2, vals[j]);
            tick();
            n_cmp++;
            if (grant !== 5'b00100 || mem_index !== 11'd0) begin
                n_err++; $display("FAIL oor_grant: idx %0d got g=%b a=%0d want g=00100 a=0",
                                  vals[j], grant, mem_index);
            end
            req = '0;
            tick();
            n_cmp++;
            if (rsp_valid !== 5'b00100 || rsp_data !== 5'b11111) begin
                n_err++; $display("FAIL oor_rsp: idx %0d got v=%b d=%b want v=00100 d=11111",
                                  vals[j], rsp_valid, rsp_data);
            end
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req = 5'b01000; set_idx(3, $urandom_range(0, CELLS - 1));
        tick();
        n_cmp++;
        if (grant !== 5'b01000) begin
            n_err++; $display("FAIL mid_grant: got %b want 01000", grant);
        end
        reset = 1'b1; req = 5'b10001;
        set_idx(0, $urandom_range(0, CELLS - 1)); set_idx(4, $urandom_range(0, CELLS - 1));
        tick();
        n_cmp++;
        if (rsp_valid !== 5'b00000) begin
            n_err++; $display("FAIL mid_rsp_in_reset: got %b want 00000", rsp_valid);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (grant !== 5'b00001 || rsp_valid !== 5'b00000) begin
            n_err++; $display("FAIL mid_after: got g=%b v=%b want g=00001 v=00000", grant, rsp_valid);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_abandon();
        do_reset();
        req = 5'b01010;
        set_idx(1, $urandom_range(0, CELLS - 1)); set_idx(3, $urandom_range(0, CELLS - 1));
        tick();
        n_cmp++;
        if (grant !== 5'b00010) begin
            n_err++; $display("FAIL abandon_grant: got %b want 00010", grant);
        end
        req = '0;
        tick();
        n_cmp++;
        if (grant !== 5'b00000 || rsp_valid !== 5'b00010) begin
            n_err++; $display("FAIL abandon_idle: got g=%b v=%b want g=00000 v=00010", grant, rsp_valid);
        end
        req = 5'b10101;
        for (int i = 0; i < N; i++) set_idx(i, $urandom_range(0, CELLS - 1));
        tick();
        n_cmp++;
        if (grant !== 5'b00100) begin
            n_err++; $display("FAIL abandon_ptr: got %b want 00100", grant);
        end
        req = '0;
        tick(); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] || m_grant[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    set_idx(i, ($urandom_range(0, 9) == 0) ? $urandom_range(CELLS, 2047)
                                                           : $urandom_range(0, CELLS - 1));
                end else if ($urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
            end
            tick();
            n_cmp++;
            if (grant !== e_grant || mem_index !== e_mem_index) begin
                n_err++; $display("FAIL rand_grant: cyc %0d got g=%b a=%0d want g=%b a=%0d",
                                  c, grant, mem_index, e_grant, e_mem_index);
            end
            n_cmp++;
            if (rsp_valid !== e_rsp_valid || rsp_data !== e_rsp_data) begin
                n_err++; $display("FAIL rand_rsp: cyc %0d got v=%b d=%h want v=%b d=%h",
                                  c, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data);
            end
        end
        req = '0;
        tick(); tick();
    endtask

    initial begin
        for (int i = 0; i < CELLS; i++) mem[i] = 5'($urandom);
        reset = 1'b1; req = '0; req_index = '0;
        m_grant = '0; m_gidx = 0; m_oor = 0; m_mem_index = 0; m_ptr = 0;
        m_rsp_valid = '0; m_rsp_data = '0;
        test_reset();
        test_single();
        test_all_five();
        test_oor();
        test_reset_midflight();
        test_abandon();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
